// File: rtl/demux8_scheduler.sv
// Round-robin burst sequencer feeding an 8-way demux from one valid/ready stream; optional beat counter under DEMUX_SCHED_STATS_EN.
// Latency: one cycle from input accept to out_valid/out_data (single holding register).
// Backpressure: in_ready drops while the held beat is blocked by out_ready[sel]; out_data is stable until consumed.
module demux8_scheduler #(
  parameter int WIDTH = 8,
  parameter int BURST = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       chan_en,
  output logic [WIDTH-1:0] out_data,
  output logic [7:0]       out_valid,
  input  logic [7:0]       out_ready,
  output logic [2:0]       sel,
  output logic             busy,
  output logic [15:0]      beat_cnt
);

  typedef enum logic [1:0] {
    ARB   = 2'd0,
    XFER  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [7:0] BURST_C = 8'(BURST);

  state_t           state, state_nxt;
  logic [2:0]       ptr, ptr_nxt;
  logic [7:0]       cnt, cnt_nxt;
  logic             hold_valid, hold_valid_nxt;
  logic [WIDTH-1:0] hold_data, hold_data_nxt;

  logic             found;
  logic [2:0]       grant;
  logic             accept;
  logic             consume;

  // Held beat leaves when the granted channel is ready; other channels' ready bits are ignored.
  assign consume = hold_valid && out_ready[ptr];
  assign accept  = in_valid && in_ready;

  // Round-robin search starting one past the current pointer; the current channel is tried last.
  always_comb begin
    found = 1'b0;
    grant = ptr;
    for (int i = 1; i <= 8; i++) begin
      if (!found && chan_en[ptr + 3'(i)]) begin
        found = 1'b1;
        grant = ptr + 3'(i);
      end
    end
  end

  // Next-state, holding register update and input handshake.
  always_comb begin
    state_nxt      = state;
    ptr_nxt        = ptr;
    cnt_nxt        = cnt;
    hold_valid_nxt = hold_valid;
    hold_data_nxt  = hold_data;
    in_ready       = 1'b0;

    if (consume) begin
      hold_valid_nxt = 1'b0;
    end

    case (state)
      ARB: begin
        if (found) begin
          ptr_nxt   = grant;
          cnt_nxt   = 8'd0;
          state_nxt = XFER;
        end
      end
      XFER: begin
        // Disabling the channel blocks the handshake in the same cycle.
        in_ready = chan_en[ptr] && (cnt < BURST_C) && (!hold_valid || out_ready[ptr]);
        if (in_valid && in_ready) begin
          hold_data_nxt  = in_data;
          hold_valid_nxt = 1'b1;
          cnt_nxt        = cnt + 8'd1;
          if (cnt + 8'd1 == BURST_C) begin
            state_nxt = DRAIN;
          end
        end
        if (!chan_en[ptr]) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        // A held beat is always delivered, even if its channel was disabled.
        if (!hold_valid || consume) begin
          state_nxt = ARB;
        end
      end
      default: begin
        state_nxt = ARB;
      end
    endcase
  end

  // State and holding register; reset discards any held beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ARB;
      ptr        <= 3'd7;
      cnt        <= 8'd0;
      hold_valid <= 1'b0;
      hold_data  <= '0;
    end else begin
      state      <= state_nxt;
      ptr        <= ptr_nxt;
      cnt        <= cnt_nxt;
      hold_valid <= hold_valid_nxt;
      hold_data  <= hold_data_nxt;
    end
  end

  assign out_data  = hold_data;
  assign out_valid = hold_valid ? (8'h01 << ptr) : 8'h00;
  assign sel       = ptr;
  assign busy      = (state != ARB);

`ifdef DEMUX_SCHED_STATS_EN
  logic [15:0] beat_q;

  // Count beats consumed downstream; wraps naturally at 16 bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      beat_q <= 16'd0;
    end else if (consume) begin
      beat_q <= beat_q + 16'd1;
    end
  end

  assign beat_cnt = beat_q;
`else
  assign beat_cnt = 16'd0;
`endif

  // accept is only meaningful for readers of this file; keep it referenced.
  logic unused_accept;
  assign unused_accept = accept;

endmodule

// File: tb/tb_demux8_scheduler.sv
// Bench for demux8_scheduler: directed scenarios plus a randomized phase against a transaction-level model.
// The model tracks grant order, delivery order, latency and the consumed-beat count.
// Outputs are sampled on the falling edge; inputs are driven 1 time unit after the rising edge.
module tb_demux8_scheduler;

  localparam int WIDTH = 8;
  localparam int BURST = 4;
`ifdef DEMUX_SCHED_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [WIDTH-1:0] in_data = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [7:0]       chan_en = 8'h00;
  logic [WIDTH-1:0] out_data;
  logic [7:0]       out_valid;
  logic [7:0]       out_ready = 8'h00;
  logic [2:0]       sel;
  logic             busy;
  logic [15:0]      beat_cnt;

  always #5 clk = ~clk;

  demux8_scheduler #(.WIDTH(WIDTH), .BURST(BURST)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .chan_en(chan_en), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .sel(sel), .busy(busy), .beat_cnt(beat_cnt)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    int         cyc;
    logic [2:0] ch;
    logic [7:0] d;
  } ev_t;

  // stimulus controls
  logic [7:0] en_v = 8'hFF;
  logic [7:0] rdy_v = 8'hFF;
  bit         rnd_mode = 1'b0;
  bit         rst_v = 1'b1;
  logic [7:0] src_q[$];

  // reference model state
  logic [7:0] exp_q[$];
  ev_t        acc_log[$];
  ev_t        dlv_log[$];
  logic [2:0] mdl_ptr = 3'd7;
  logic [15:0] mdl_bcnt = 16'd0;
  logic [7:0] prev_en = 8'h00;
  bit         prev_busy = 1'b0;
  bit         prev_acc = 1'b0;
  logic [7:0] prev_acc_d = 8'h00;
  bit         prev_stall = 1'b0;
  logic [7:0] prev_out_d = 8'h00;
  int         grant_acc = 0;
  int         cyc = 0;

  // Next enabled channel after p, wrapping, p itself last.
  function automatic logic [2:0] next_en(input logic [2:0] p, input logic [7:0] en);
    for (int k = 1; k <= 8; k++) begin
      if (en[(int'(p) + k) % 8]) return 3'((int'(p) + k) % 8);
    end
    return p;
  endfunction

  task automatic tick();
    bit  acc, cons;
    ev_t e;
    @(posedge clk);
    #1;
    rst       = rst_v;
    chan_en   = en_v;
    out_ready = rnd_mode ? 8'($urandom) : rdy_v;
    in_valid  = (src_q.size() != 0) && (!rnd_mode || ($urandom_range(3) != 0));
    in_data   = (src_q.size() != 0) ? src_q[0] : 8'h00;
    @(negedge clk);
    cyc++;
    if (rst) begin
      mdl_ptr = 3'd7; mdl_bcnt = 16'd0; exp_q.delete();
      prev_busy = 1'b0; prev_acc = 1'b0; prev_stall = 1'b0; prev_en = chan_en;
      return;
    end
    chk("beat_cnt", beat_cnt, STATS ? mdl_bcnt : 16'd0);
    if (busy && !prev_busy) begin
      chk("grant_en", prev_en != 8'h00, 1);
      chk("grant_sel", sel, next_en(mdl_ptr, prev_en));
      mdl_ptr   = next_en(mdl_ptr, prev_en);
      grant_acc = 0;
    end
    chk("sel_hold", sel, mdl_ptr);
    chk("ovld", out_valid, (out_valid != 8'h00) ? (8'h01 << mdl_ptr) : 8'h00);
    if (prev_acc) begin
      chk("lat_vld", out_valid[mdl_ptr], 1);
      chk("lat_dat", out_data, prev_acc_d);
    end
    if (prev_stall) chk("stall_dat", out_data, prev_out_d);
    if (!busy || !chan_en[mdl_ptr]) chk("in_rdy_off", in_ready, 0);
    acc  = in_valid && in_ready;
    cons = out_valid[mdl_ptr] && out_ready[mdl_ptr];
    if (cons) begin
      if (exp_q.size() == 0) begin
        chk("cons_empty", 1, 0);
      end else begin
        chk("order", out_data, exp_q[0]);
        e.cyc = cyc; e.ch = mdl_ptr; e.d = out_data;
        dlv_log.push_back(e);
        void'(exp_q.pop_front());
      end
      mdl_bcnt++;
    end
    if (acc) begin
      e.cyc = cyc; e.ch = mdl_ptr; e.d = in_data;
      acc_log.push_back(e);
      exp_q.push_back(in_data);
      void'(src_q.pop_front());
      grant_acc++;
      chk("burst_len", grant_acc <= BURST, 1);
    end
    prev_stall = (out_valid != 8'h00) && !cons;
    prev_out_d = out_data;
    prev_acc   = acc;
    prev_acc_d = in_data;
    prev_busy  = busy;
    prev_en    = chan_en;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_in_ready"}, in_ready, 0);
    chk({tag, "_out_valid"}, out_valid, 8'h00);
    chk({tag, "_out_data"}, out_data, 8'h00);
    chk({tag, "_sel"}, sel, 3'd7);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_beat_cnt"}, beat_cnt, 16'd0);
  endtask

  task automatic do_reset();
    rst_v = 1'b1;
    tick();
    rst_v = 1'b0;
    src_q.delete(); acc_log.delete(); dlv_log.delete();
    tick();
    chk_reset_vals("rst");
  endtask

  task automatic run_idle(input int max_cyc);
    for (int i = 0; i < max_cyc; i++) begin
      if (src_q.size() == 0 && exp_q.size() == 0) break;
      tick();
    end
    chk("idle_timeout", src_q.size() + exp_q.size(), 0);
    repeat (3) tick();
  endtask

  task automatic wait_ovld(input string tag);
    for (int i = 0; i < 30; i++) begin
      if (out_valid != 8'h00) break;
      tick();
    end
    chk(tag, out_valid != 8'h00, 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog");
    $fatal(1, "timeout");
  end

  initial begin
    // T1: all channels enabled, 16 beats, no backpressure
    en_v = 8'hFF; rdy_v = 8'hFF;
    do_reset();
    for (int k = 1; k <= 16; k++) src_q.push_back(8'(k));
    run_idle(200);
    chk("t1_n", dlv_log.size(), 16);
    for (int k = 0; k < 16 && k < dlv_log.size(); k++) begin
      chk("t1_ch", dlv_log[k].ch, k / 4);
      chk("t1_d", dlv_log[k].d, k + 1);
    end
    if (acc_log.size() >= 16) begin
      chk("t1_tput", acc_log[1].cyc - acc_log[0].cyc, 1);
      chk("t1_gap", acc_log[4].cyc - acc_log[3].cyc, 3);
      chk("t1_gap2", acc_log[12].cyc - acc_log[11].cyc, 3);
    end else begin
      chk("t1_acc_n", acc_log.size(), 16);
    end

    // T2: sparse enable mask 1000_0100
    en_v = 8'h84;
    do_reset();
    for (int k = 0; k < 12; k++) src_q.push_back(8'h40 + 8'(k));
    run_idle(200);
    chk("t2_n", dlv_log.size(), 12);
    for (int k = 0; k < 12 && k < dlv_log.size(); k++)
      chk("t2_ch", dlv_log[k].ch, ((k / 4) == 1) ? 7 : 2);

    // T3: channel 0 stalled for 5 cycles holding A5
    en_v = 8'hFF; rdy_v = 8'hFE;
    do_reset();
    src_q.push_back(8'hA5); src_q.push_back(8'h11); src_q.push_back(8'h22); src_q.push_back(8'h33);
    wait_ovld("t3_wait");
    for (int i = 0; i < 5; i++) begin
      chk("t3_dat", out_data, 8'hA5);
      chk("t3_ovld", out_valid, 8'h01);
      chk("t3_rdy", in_ready, 0);
      if (i < 4) tick();
    end
    rdy_v = 8'hFF;
    run_idle(100);
    chk("t3_n", dlv_log.size(), 4);
    if (dlv_log.size() == 4) chk("t3_first", dlv_log[0].d, 8'hA5);
    if (acc_log.size() == 4) chk("t3_tput", acc_log[3].cyc - acc_log[1].cyc, 2);

    // T4: disable channel 3 after two beats of its burst
    en_v = 8'h28; rdy_v = 8'hFF;
    do_reset();
    for (int k = 0; k < 6; k++) src_q.push_back(8'h30 + 8'(k));
    for (int i = 0; i < 30; i++) begin
      if (acc_log.size() >= 2) break;
      tick();
    end
    chk("t4_acc2", acc_log.size(), 2);
    en_v = 8'h20;
    tick();
    chk("t4_rdy", in_ready, 0);
    chk("t4_ovld", out_valid, 8'h08);
    run_idle(100);
    chk("t4_n", dlv_log.size(), 6);
    for (int k = 0; k < 6 && k < dlv_log.size(); k++)
      chk("t4_ch", dlv_log[k].ch, (k < 2) ? 3 : 5);

    // T6: ten consumed beats for the statistics counter
    en_v = 8'hFF; rdy_v = 8'hFF;
    do_reset();
    for (int k = 0; k < 10; k++) src_q.push_back(8'(k * 3));
    run_idle(100);
    chk("t6_bcnt", beat_cnt, STATS ? 16'd10 : 16'd0);

    // T5: reset mid-burst with a held beat (counter nonzero beforehand when enabled)
    rdy_v = 8'h00;
    for (int k = 0; k < 4; k++) src_q.push_back(8'h90 + 8'(k));
    wait_ovld("t5_wait");
    rst_v = 1'b1;
    tick();
    rst_v = 1'b0;
    src_q.delete(); acc_log.delete(); dlv_log.delete();
    tick();
    chk_reset_vals("t5");
    rdy_v = 8'hFF;
    src_q.push_back(8'h77);
    run_idle(50);
    chk("t5_n", dlv_log.size(), 1);
    if (dlv_log.size() == 1) begin
      chk("t5_ch", dlv_log[0].ch, 0);
      chk("t5_d", dlv_log[0].d, 8'h77);
    end

    // T7: randomized enables, valid, ready and occasional reset
    do_reset();
    rnd_mode = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(19) == 0) en_v = 8'($urandom);
      while (src_q.size() < 4) src_q.push_back(8'($urandom));
      rst_v = ($urandom_range(299) == 0);
      tick();
    end
    rst_v = 1'b0;
    rnd_mode = 1'b0; en_v = 8'hFF; rdy_v = 8'hFF;
    run_idle(300);
    chk("t7_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
